// File: rtl/md_sequencer.sv
// Multiply/divide sequencer for the HI/LO unit.
// Division: 32-cycle radix-2 restoring shift-subtract on operand magnitudes, then sign fixup.
// Multiplication: 32-cycle shift-add on magnitudes by default; define MD_FAST_MULT_EN to
// compute the product in a single MUL cycle instead.
// md_result is registered on entry to DONE and held until the next completion.
module md_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        mult_en,
  input  logic        div_en,
  input  logic        is_signed,
  input  logic [31:0] md_src1,
  input  logic [31:0] md_src2,
  input  logic        flush,
  output logic        busy,
  output logic        md_complete,
  output logic [63:0] md_result
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMul  = 2'd1;
  localparam logic [1:0] StDiv  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [32:0] a_q, a_d;        // partial remainder / upper partial product
  logic [31:0] b_q, b_d;        // quotient/dividend shifter or multiplier shifter
  logic [31:0] opd_q, opd_d;    // divisor or multiplicand magnitude
  logic [31:0] src1_q, src1_d;  // raw dividend, returned as HI on divide by zero
  logic        neg_q, neg_d;    // negate quotient / product
  logic        rneg_q, rneg_d;  // negate remainder (dividend was negative)
  logic        div0_q, div0_d;
  logic [63:0] res_q, res_d;

  logic        accept;
  logic [31:0] mag1, mag2;
  logic [32:0] div_shift, div_diff, div_a;
  logic        div_ge;
  logic [31:0] div_b;
  logic [63:0] div_res, prod_mag, mul_res;
`ifndef MD_FAST_MULT_EN
  logic [32:0] mul_sum, mul_a;
  logic [31:0] mul_b;
`endif

  assign accept = (state_q == StIdle) && !flush && (mult_en || div_en);
  assign mag1   = (is_signed && md_src1[31]) ? -md_src1 : md_src1;
  assign mag2   = (is_signed && md_src2[31]) ? -md_src2 : md_src2;

  // One restoring-divide step, one shift-add step, and the fixed-up final results.
  always_comb begin
    div_shift = {a_q[31:0], b_q[31]};
    div_diff  = div_shift - {1'b0, opd_q};
    div_ge    = div_shift >= {1'b0, opd_q};
    div_a     = div_ge ? div_diff : div_shift;
    div_b     = {b_q[30:0], div_ge};
    if (div0_q) begin
      div_res = {src1_q, 32'hFFFF_FFFF};
    end else begin
      div_res = {(rneg_q ? -div_a[31:0] : div_a[31:0]), (neg_q ? -div_b : div_b)};
    end
`ifdef MD_FAST_MULT_EN
    prod_mag = {32'd0, opd_q} * {32'd0, b_q};
`else
    mul_sum  = a_q + (b_q[0] ? {1'b0, opd_q} : 33'd0);
    mul_a    = {1'b0, mul_sum[32:1]};
    mul_b    = {mul_sum[0], b_q[31:1]};
    prod_mag = {mul_a[31:0], mul_b};
`endif
    mul_res  = neg_q ? -prod_mag : prod_mag;
  end

  // Next-state and datapath sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    opd_d   = opd_q;
    src1_d  = src1_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    div0_d  = div0_q;
    res_d   = res_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          cnt_d  = 5'd0;
          a_d    = 33'd0;
          src1_d = md_src1;
          neg_d  = is_signed && (md_src1[31] ^ md_src2[31]);
          rneg_d = is_signed && md_src1[31];
          div0_d = (md_src2 == 32'd0);
          if (mult_en) begin
            state_d = StMul;
            opd_d   = mag1;
            b_d     = mag2;
          end else begin
            state_d = StDiv;
            opd_d   = mag2;
            b_d     = mag1;
          end
        end
      end
      StMul: begin
        if (flush) begin
          state_d = StIdle;
          cnt_d   = 5'd0;
        end else begin
`ifdef MD_FAST_MULT_EN
          state_d = StDone;
          res_d   = mul_res;
`else
          a_d   = mul_a;
          b_d   = mul_b;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d = StDone;
            res_d   = mul_res;
          end
`endif
        end
      end
      StDiv: begin
        if (flush) begin
          state_d = StIdle;
          cnt_d   = 5'd0;
        end else begin
          a_d   = div_a;
          b_d   = div_b;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d = StDone;
            res_d   = div_res;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State registers; synchronous reset overrides flush and requests.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 5'd0;
      a_q     <= 33'd0;
      b_q     <= 32'd0;
      opd_q   <= 32'd0;
      src1_q  <= 32'd0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      div0_q  <= 1'b0;
      res_q   <= 64'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      opd_q   <= opd_d;
      src1_q  <= src1_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      div0_q  <= div0_d;
      res_q   <= res_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign md_complete = (state_q == StDone);
  assign md_result   = res_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Scoreboard bench for md_sequencer: expected result and completion cycle are queued at issue
// and compared when md_complete pulses. Honours MD_FAST_MULT_EN for multiply latency.
module tb_md_sequencer;

`ifdef MD_FAST_MULT_EN
  localparam int MulLat = 2;
`else
  localparam int MulLat = 33;
`endif
  localparam int DivLat = 33;

  logic        clk = 1'b0;
  logic        reset, mult_en, div_en, is_signed, flush;
  logic [31:0] md_src1, md_src2;
  logic        busy, md_complete;
  logic [63:0] md_result;

  md_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .mult_en    (mult_en),
    .div_en     (div_en),
    .is_signed  (is_signed),
    .md_src1    (md_src1),
    .md_src2    (md_src2),
    .flush      (flush),
    .busy       (busy),
    .md_complete(md_complete),
    .md_result  (md_result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    int          at;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] last_exp = 64'd0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] model(input bit is_div, input bit sgn,
                                         input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] q, r;
    if (!is_div) begin
      if (sgn) return $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      return {32'd0, a} * {32'd0, b};
    end
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
      return {r, q};
    end
    return {a % b, a / b};
  endfunction

  // Pop and compare on every completion pulse, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && md_complete) begin
      if (sb.size() == 0) begin
        check_val("unexpected_pulse", {63'd0, md_complete}, 64'd0);
      end else begin
        e = sb.pop_front();
        check_val("done_cycle", 64'(cyc), 64'(e.at));
        check_val("md_result", md_result, e.res);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  // Drive a request in the current cycle T; returns T. Leaves the bench at T+1.
  task automatic start(input bit mul, input bit div, input bit sgn, input logic [31:0] a,
                       input logic [31:0] b, input bit push, input logic [63:0] exp,
                       input int lat, output int t);
    mult_en   = mul;
    div_en    = div;
    is_signed = sgn;
    md_src1   = a;
    md_src2   = b;
    t         = cyc;
    if (push) begin
      sb.push_back('{res: exp, at: t + lat});
      last_exp = exp;
    end
    tick();
    mult_en = 1'b0;
    div_en  = 1'b0;
    check_val("busy_on", {63'd0, busy}, 64'd1);
  endtask

  task automatic wait_idle;
    for (int k = 0; k < 40 && busy; k++) tick();
    check_val("idle_reached", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int t, t2;
    bit d, s;
    logic [31:0] a, b;
    logic [63:0] e;

    reset = 1'b1; mult_en = 1'b0; div_en = 1'b0; is_signed = 1'b0; flush = 1'b0;
    md_src1 = 32'd0; md_src2 = 32'd0;
    repeat (3) tick();
    check_val("rst_busy", {63'd0, busy}, 64'd0);
    check_val("rst_complete", {63'd0, md_complete}, 64'd0);
    check_val("rst_result", md_result, 64'd0);
    reset = 1'b0;
    tick();

    // DIVU 100/7
    start(1'b0, 1'b1, 1'b0, 32'd100, 32'd7, 1'b1, {32'd2, 32'd14}, DivLat, t);
    wait_idle();

    // DIV -7/2, with a multiply request mid-operation that must be ignored
    start(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD},
          DivLat, t);
    wait_until(t + 5);
    mult_en = 1'b1;
    tick();
    mult_en = 1'b0;
    wait_idle();

    // MULT / MULTU -1 * 2
    start(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, MulLat, t);
    wait_idle();
    start(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2, 1'b1, 64'h0000_0001_FFFF_FFFE, MulLat, t);
    wait_idle();

    // DIVU 5/0
    start(1'b0, 1'b1, 1'b0, 32'd5, 32'd0, 1'b1, {32'd5, 32'hFFFF_FFFF}, DivLat, t);
    wait_idle();

    // Signed overflow case
    start(1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'd0, 32'h8000_0000},
          DivLat, t);
    wait_idle();

    // Both enables: multiply wins
    start(1'b1, 1'b1, 1'b1, 32'd6, 32'hFFFF_FFF9, 1'b1, 64'hFFFF_FFFF_FFFF_FFD6, MulLat, t);
    wait_idle();

    // Flush at T+10 of a divide, then DIVU 9/3 at T+11
    start(1'b0, 1'b1, 1'b0, 32'd1000, 32'd3, 1'b0, 64'd0, DivLat, t);
    wait_until(t + 10);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_val("flush_busy", {63'd0, busy}, 64'd0);
    check_val("flush_cycle", 64'(cyc), 64'(t + 11));
    start(1'b0, 1'b1, 1'b0, 32'd9, 32'd3, 1'b1, {32'd0, 32'd3}, DivLat, t2);
    wait_idle();

    // Flush during DONE is ignored
    start(1'b0, 1'b1, 1'b0, 32'd50, 32'd5, 1'b1, {32'd0, 32'd10}, DivLat, t);
    wait_until(t + 33);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_idle();

    // Reset at T+5 of a divide with a competing request
    start(1'b0, 1'b1, 1'b0, 32'd77, 32'd4, 1'b0, 64'd0, DivLat, t);
    wait_until(t + 5);
    reset = 1'b1; div_en = 1'b1; md_src1 = 32'd8; md_src2 = 32'd2;
    tick();
    reset = 1'b0; div_en = 1'b0;
    check_val("rst_mid_busy", {63'd0, busy}, 64'd0);
    check_val("rst_mid_complete", {63'd0, md_complete}, 64'd0);
    check_val("rst_mid_result", md_result, 64'd0);
    tick();
    check_val("rst_not_accepted", {63'd0, busy}, 64'd0);
    repeat (40) tick();

    // Randomised mix against the behavioural model
    for (int i = 0; i < 8; i++) begin
      d = (i % 2) == 0;
      s = $urandom_range(0, 1) == 1;
      a = $urandom;
      b = (i == 2) ? 32'd0 : ((i % 4) == 0 ? $urandom_range(1, 9) : $urandom);
      e = model(d, s, a, b);
      start(!d, d, s, a, b, 1'b1, e, d ? DivLat : MulLat, t);
      wait_idle();
    end

    // Result holds between completions
    repeat (3) tick();
    check_val("result_hold", md_result, last_exp);
    check_val("sb_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
